// File: rtl/wb_burst_mem_slave.sv
// Wishbone B3 memory slave with wait states, registered-feedback CTI/BTE bursts,
// an address window that answers with err, and saturating beat/error statistics.
module wb_burst_mem_slave #(
   parameter int                DATA_W      = 32,
   parameter int                ADDR_W      = 32,
   parameter int                DEPTH       = 1024,
   parameter int                WAIT_STATES = 0,
   parameter logic [ADDR_W-1:0] ERR_BASE    = 32'hFFFF_0000,
   parameter logic [ADDR_W-1:0] ERR_MASK    = 32'hFFFF_0000,
   localparam int               SEL_W       = DATA_W / 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   output logic [DATA_W-1:0] dat_o,
   input  logic [SEL_W-1:0]  sel_i,
   input  logic              we_i,
   input  logic              cyc_i,
   input  logic              stb_i,
   input  logic [2:0]        cti_i,
   input  logic [1:0]        bte_i,
   output logic              ack_o,
   output logic              err_o,
   output logic [15:0]       beat_cnt_o,
   output logic [7:0]        err_cnt_o
);

   localparam int LSB   = (SEL_W > 1) ? $clog2(SEL_W) : 0;
   localparam int IDX_W = $clog2(DEPTH);
   localparam int WW    = ADDR_W - LSB;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_INC     = 3'b010;

   typedef enum logic [1:0] {IDLE, WAIT, BEAT, ERR} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   adr_q, adr_d;
   logic                we_q, we_d;
   logic [2:0]          cti_q, cti_d;
   logic [1:0]          bte_q, bte_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic [DATA_W-1:0]   dat_q, dat_d;
   logic [15:0]         beat_cnt_q, beat_cnt_d;
   logic [7:0]          err_cnt_q, err_cnt_d;

   logic [DATA_W-1:0]   mem [DEPTH];

   logic                acc;
   logic [WW-1:0]       word, word_inc, wrap_mask, next_word;
   logic [ADDR_W-1:0]   nxt_adr;

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      return a[LSB +: IDX_W];
   endfunction

   function automatic logic err_hit(input logic [ADDR_W-1:0] a);
      return (a & ERR_MASK) == (ERR_BASE & ERR_MASK);
   endfunction

   assign acc   = cyc_i & stb_i;
   assign ack_o = (state_q == BEAT) & acc;
   assign err_o = (state_q == ERR) & acc;

   assign dat_o      = dat_q;
   assign beat_cnt_o = beat_cnt_q;
   assign err_cnt_o  = err_cnt_q;

   // Burst address: wrap bursts only advance the low 2/3/4 word-index bits.
   always_comb begin
      word     = WW'(adr_q >> LSB);
      word_inc = word + WW'(1);
      case (bte_q)
         2'b01:   wrap_mask = WW'(3);
         2'b10:   wrap_mask = WW'(7);
         2'b11:   wrap_mask = WW'(15);
         default: wrap_mask = '1;
      endcase
      next_word = (word & ~wrap_mask) | (word_inc & wrap_mask);
      nxt_adr   = (ADDR_W'(next_word) << LSB) | (adr_q & ADDR_W'(SEL_W - 1));
   end

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      we_d       = we_q;
      cti_d      = cti_q;
      bte_d      = bte_q;
      wcnt_d     = wcnt_q;
      dat_d      = dat_q;
      beat_cnt_d = (ack_o && beat_cnt_q != 16'hFFFF) ? beat_cnt_q + 16'd1 : beat_cnt_q;
      err_cnt_d  = (err_o && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

      case (state_q)
         IDLE: begin
            if (acc) begin
               adr_d = adr_i;
               we_d  = we_i;
               cti_d = cti_i;
               bte_d = bte_i;
               if (err_hit(adr_i)) begin
                  state_d = ERR;
               end else if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  wcnt_d  = 4'(WAIT_STATES);
               end else begin
                  state_d = BEAT;
                  dat_d   = mem[idx_of(adr_i)];
               end
            end
         end
         WAIT: begin
            if (!acc) begin
               state_d = IDLE;
            end else if (wcnt_q == 4'd1) begin
               state_d = BEAT;
               dat_d   = mem[idx_of(adr_q)];
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         BEAT: begin
            // Anything other than an incrementing-burst cti (incl. 111) ends the cycle.
            if (!acc || cti_q == CTI_CLASSIC || cti_i != CTI_INC) begin
               state_d = IDLE;
            end else begin
               adr_d = nxt_adr;
               if (err_hit(nxt_adr)) begin
                  state_d = ERR;
               end else begin
                  dat_d = mem[idx_of(nxt_adr)];
               end
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= IDLE;
         adr_q      <= '0;
         we_q       <= 1'b0;
         cti_q      <= '0;
         bte_q      <= '0;
         wcnt_q     <= '0;
         dat_q      <= '0;
         beat_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         adr_q      <= adr_d;
         we_q       <= we_d;
         cti_q      <= cti_d;
         bte_q      <= bte_d;
         wcnt_q     <= wcnt_d;
         dat_q      <= dat_d;
         beat_cnt_q <= beat_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   // Memory contents survive reset; ack_o is already forced low while reset is held.
   always_ff @(posedge wb_clk_i) begin
      if (ack_o && we_q) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (sel_i[b]) begin
               mem[idx_of(adr_q)][b*8 +: 8] <= dat_i[b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_wb_burst_mem_slave.sv
// Directed bench for wb_burst_mem_slave: a zero-wait and a three-wait instance share one
// master driver; a negedge monitor pops expected responses from a queue.
module tb_wb_burst_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tgt = 1'b0;
   logic        cyc = 1'b0;
   logic        stb = 1'b0;
   logic [31:0] adr = '0;
   logic [31:0] dat_w = '0;
   logic [3:0]  sel = '0;
   logic        we = 1'b0;
   logic [2:0]  cti = '0;
   logic [1:0]  bte = '0;

   logic [31:0] dat0, dat3;
   logic        ack0, ack3, err0, err3;
   logic [15:0] bc0, bc3;
   logic [7:0]  ec0, ec3;
   logic        cyc0, cyc3, stb0, stb3;
   logic        ack_s, err_s;
   logic [31:0] dat_s;

   int          n_chk = 0;
   int          n_fail = 0;
   int          lat;

   // kind: 0 = ack without data check, 1 = ack with read data, 2 = err
   logic [1:0]  kind_q[$];
   logic [31:0] exp_q[$];
   logic [1:0]  mon_k;
   logic [31:0] mon_d;

   always #5 clk = ~clk;

   assign cyc0  = cyc & ~tgt;
   assign stb0  = stb & ~tgt;
   assign cyc3  = cyc & tgt;
   assign stb3  = stb & tgt;
   assign ack_s = tgt ? ack3 : ack0;
   assign err_s = tgt ? err3 : err0;
   assign dat_s = tgt ? dat3 : dat0;

   wb_burst_mem_slave #(.WAIT_STATES(0)) u_dut0 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat0),
      .sel_i(sel), .we_i(we), .cyc_i(cyc0), .stb_i(stb0), .cti_i(cti), .bte_i(bte),
      .ack_o(ack0), .err_o(err0), .beat_cnt_o(bc0), .err_cnt_o(ec0)
   );

   wb_burst_mem_slave #(.WAIT_STATES(3)) u_dut3 (
      .wb_clk_i(clk), .wb_rst_i(rst_n), .adr_i(adr), .dat_i(dat_w), .dat_o(dat3),
      .sel_i(sel), .we_i(we), .cyc_i(cyc3), .stb_i(stb3), .cti_i(cti), .bte_i(bte),
      .ack_o(ack3), .err_o(err3), .beat_cnt_o(bc3), .err_cnt_o(ec3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_ack();
      kind_q.push_back(2'd0);
      exp_q.push_back(32'h0);
   endtask

   task automatic push_rd(input logic [31:0] d);
      kind_q.push_back(2'd1);
      exp_q.push_back(d);
   endtask

   task automatic push_err();
      kind_q.push_back(2'd2);
      exp_q.push_back(32'h0);
   endtask

   // Monitor: every ack/err cycle consumes one expected response.
   always @(negedge clk) begin
      if (ack_s || err_s) begin
         if (ack_s && err_s) chk("ack_err_exclusive", {ack_s, err_s}, 2'b00);
         if (kind_q.size() == 0) begin
            chk("unexpected_response", {ack_s, err_s}, 2'b00);
         end else begin
            mon_k = kind_q.pop_front();
            mon_d = exp_q.pop_front();
            chk("resp_is_err", err_s, (mon_k == 2'd2));
            if (mon_k == 2'd1) chk("rd_data", dat_s, mon_d);
         end
      end
   end

   // Master driver. adr stays at the start address for the whole burst so the
   // slave has to generate burst addresses on its own.
   task automatic bus_cycle(input logic t, input logic [31:0] a, input logic w,
                            input logic [3:0] s, input logic [31:0] wbase, input int n,
                            input logic burst, input logic [1:0] b, output int first_lat);
      int  edges;
      int  beat;
      bit  done;
      bit  last;
      @(posedge clk); #1;
      tgt = t; cyc = 1'b1; stb = 1'b1; adr = a; we = w; sel = s; dat_w = wbase; bte = b;
      cti = !burst ? 3'b000 : (n == 1 ? 3'b111 : 3'b010);
      first_lat = -1; beat = 0; done = 0;
      @(posedge clk); #1;
      edges = 1;
      while (!done) begin
         if (ack_s || err_s) begin
            if (beat == 0) first_lat = edges;
            last = err_s || !burst || (beat == n - 1);
            @(posedge clk); #1;
            edges++;
            if (last) begin
               done = 1;
            end else begin
               beat++;
               dat_w = wbase + beat;
               cti = (beat == n - 1) ? 3'b111 : 3'b010;
            end
         end else if (edges > 64) begin
            chk("response_timeout", 32'(edges), 32'd0);
            done = 1;
         end else begin
            @(posedge clk); #1;
            edges++;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = 3'b000;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack0", ack0, 0);      chk("rst_err0", err0, 0);
      chk("rst_dat0", dat0, 0);      chk("rst_bc0", bc0, 0);
      chk("rst_ec0", ec0, 0);        chk("rst_bc3", bc3, 0);
      rst_n = 1'b1;

      // 1: zero-wait classic write then read
      push_ack();
      bus_cycle(0, 32'h100, 1, 4'hF, 32'hDEADBEEF, 1, 0, 2'b00, lat);
      chk("t1_wr_lat", lat, 1);
      push_rd(32'hDEADBEEF);
      bus_cycle(0, 32'h100, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      chk("t1_rd_lat", lat, 1);
      chk("t1_beat_cnt", bc0, 2);

      // 2: three wait states, partial byte write
      push_ack();
      bus_cycle(1, 32'h40, 1, 4'hF, 32'hAABBCCDD, 1, 0, 2'b00, lat);
      chk("t2_wr_lat", lat, 4);
      push_ack();
      bus_cycle(1, 32'h40, 1, 4'b0101, 32'h11223344, 1, 0, 2'b00, lat);
      push_rd(32'hAA22CC44);
      bus_cycle(1, 32'h40, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      chk("t2_rd_lat", lat, 4);
      chk("t2_beat_cnt", bc3, 3);

      // 3: fill 0x00..0x0C, then wrap4 read burst from 0x0C
      for (int i = 0; i < 4; i++) push_ack();
      bus_cycle(0, 32'h0, 1, 4'hF, 32'hC000_0000, 4, 1, 2'b00, lat);
      push_rd(32'hC000_0003); push_rd(32'hC000_0000);
      push_rd(32'hC000_0001); push_rd(32'hC000_0002);
      bus_cycle(0, 32'h0C, 0, 4'hF, 32'h0, 4, 1, 2'b01, lat);
      chk("t3_lat", lat, 1);
      chk("t3_beat_cnt", bc0, 10);

      // 4: linear 8-beat write burst, classic read of the last word
      for (int i = 0; i < 8; i++) push_ack();
      bus_cycle(0, 32'h200, 1, 4'hF, 32'hA000_0000, 8, 1, 2'b00, lat);
      push_rd(32'hA000_0007);
      bus_cycle(0, 32'h21C, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      chk("t4_beat_cnt", bc0, 19);

      // wrap8 read burst from 0x218 wraps to 0x200
      push_rd(32'hA000_0006); push_rd(32'hA000_0007);
      push_rd(32'hA000_0000); push_rd(32'hA000_0001);
      bus_cycle(0, 32'h218, 0, 4'hF, 32'h0, 4, 1, 2'b10, lat);
      chk("wrap8_beat_cnt", bc0, 23);

      // 5: error window, classic and mid-burst
      push_err();
      bus_cycle(0, 32'hFFFF_0010, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      chk("t5_err_lat", lat, 1);
      chk("t5_err_cnt", ec0, 1);
      chk("t5_beat_cnt", bc0, 23);
      push_ack();
      bus_cycle(0, 32'h0000_0FFC, 1, 4'hF, 32'h0BAD_F00D, 1, 0, 2'b00, lat);
      push_rd(32'h0BAD_F00D); push_err();
      bus_cycle(0, 32'hFFFE_FFFC, 0, 4'hF, 32'h0, 4, 1, 2'b00, lat);
      chk("t5_burst_err_cnt", ec0, 2);
      chk("t5_burst_beat_cnt", bc0, 25);

      // 6: reset during beat 2 of a write burst
      for (int i = 0; i < 4; i++) push_ack();
      bus_cycle(0, 32'h300, 1, 4'hF, 32'h5000_0000, 4, 1, 2'b00, lat);
      push_ack();
      @(posedge clk); #1;
      tgt = 0; cyc = 1; stb = 1; adr = 32'h300; we = 1; sel = 4'hF;
      dat_w = 32'h6000_0000; cti = 3'b010; bte = 2'b00;
      @(posedge clk); #1;
      chk("t6_beat1_ack", ack0, 1);
      @(posedge clk); #1;
      dat_w = 32'h6000_0001;
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_ack", ack0, 0);    chk("t6_rst_err", err0, 0);
      chk("t6_rst_dat", dat0, 0);    chk("t6_rst_bc", bc0, 0);
      chk("t6_rst_ec", ec0, 0);      chk("t6_rst_bc3", bc3, 0);
      cyc = 0; stb = 0; we = 0; cti = 3'b000;
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_rd(32'h6000_0000);
      bus_cycle(0, 32'h300, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      push_rd(32'h5000_0002);
      bus_cycle(0, 32'h308, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      push_rd(32'h5000_0003);
      bus_cycle(0, 32'h30C, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      push_rd(32'hDEADBEEF);
      bus_cycle(0, 32'h100, 0, 4'hF, 32'h0, 1, 0, 2'b00, lat);
      chk("t6_beat_cnt_after", bc0, 4);

      repeat (2) @(posedge clk);
      chk("queue_drained", kind_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_burst_mem_slave.md
Name: wb_burst_mem_slave

Overview:
Parametrised Wishbone B3 memory slave that models system memory for the Ethernet MAC's DMA master port (m_wb_* bus). It generalises the plain single-access slave memory. New features:
- configurable data width and depth
- programmable wait states
- registered-feedback incrementing and wrapping bursts (CTI/BTE)
- an error-response address window
- access statistics

It sits in the testbench environment on the MAC master side and backs TX/RX buffer descriptors and frame data.

Parameters:
DATA_W, 32, data bus width in bits (multiple of 8); SEL_W = DATA_W/8
ADDR_W, 32, byte address width
DEPTH, 1024, memory depth in DATA_W words (power of two)
WAIT_STATES, 0, cycles inserted before the first beat of every cycle (0..15)
ERR_BASE, 32'hFFFF_0000, base byte address of the error window
ERR_MASK, 32'hFFFF_0000, address bits compared against ERR_BASE; a match forces an err response

Ports:
wb_clk_i  in  1  Wishbone clock
wb_rst_i  in  1  asynchronous active-low reset
adr_i  in  ADDR_W  byte address from the MAC master
dat_i  in  DATA_W  write data
dat_o  out  DATA_W  read data
sel_i  in  SEL_W  byte selects
we_i  in  1  write enable
cyc_i  in  1  bus cycle
stb_i  in  1  strobe
cti_i  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
ack_o  out  1  acknowledge
err_o  out  1  error response
beat_cnt_o  out  16  total acked beats since reset; saturates at 16'hFFFF
err_cnt_o  out  8  total err responses since reset; saturates at 8'hFF

Behaviour:
- Clock and reset: one clock, wb_clk_i. wb_rst_i is asynchronous and active-low.
- Reset values: ack_o=0, err_o=0, dat_o=0, beat_cnt_o=0, err_cnt_o=0, FSM=IDLE. Memory array contents are not cleared.
- Word index is adr[ADDR_W-1:log2(SEL_W)] mod DEPTH; wrap-around at DEPTH is silent.
- Error window: a hit is (adr_i & ERR_MASK) == (ERR_BASE & ERR_MASK).
- FSM states: IDLE, WAIT, BEAT, ERR.
- IDLE: on cyc_i&stb_i, latch adr/we/cti/bte.
  - Hit in the error window -> ERR.
  - Otherwise, WAIT_STATES > 0 -> WAIT with counter = WAIT_STATES.
  - Otherwise -> BEAT.
- First-beat latency: ack_o rises exactly WAIT_STATES+1 cycles after stb_i is first sampled high.
- WAIT: decrement each cycle; at 1 -> BEAT. If cyc_i or stb_i drops -> IDLE with no ack.
- BEAT: ack_o=1 for this cycle.
  - Read: dat_o holds mem[current index], registered, valid with ack_o.
  - Write: bytes with sel_i set are written to mem[current index] on the acked edge; other bytes are unchanged.
- Leaving BEAT (checked on the acked edge):
  - Latched cycle classic (cti=000), or cti_i=111 on that edge, or stb_i low -> IDLE. ack_o is low the next cycle.
  - cti_i=010 and stb_i high -> stay in BEAT with back-to-back acks and no wait states.
- Burst address generation: the next index is computed internally from the current index, not from adr_i.
  - bte 00: index+1.
  - bte 01/10/11: the low 2/3/4 bits of the index increment modulo 4/8/16; upper bits are held.
- Each burst beat re-checks the error window on its generated address; a hit -> ERR on that beat instead of ack.
- ERR: err_o=1 for one cycle, ack_o=0, no memory write, err_cnt_o++. The burst is terminated -> IDLE.
- ack_o and err_o are never high in the same cycle.
- Outputs during non-acked cycles:
  - dat_o retains its last value.
  - ack_o and err_o are asserted only while cyc_i&stb_i are high; if cyc_i drops in any state -> IDLE next cycle with no ack.
- beat_cnt_o increments on every ack_o cycle.
- Reset asserted mid-burst: immediate return to IDLE with outputs at reset values. Pending writes not yet acked are discarded.

Test Plan:
1. WAIT_STATES=0, classic write 32'hDEADBEEF to 0x100 with sel=4'hF, then classic read of 0x100 -> ack_o one cycle after stb each time; read dat_o=32'hDEADBEEF; beat_cnt_o=2.
2. WAIT_STATES=3, classic write of 32'h11223344 to 0x40 with sel=4'b0101 over existing 32'hAABBCCDD -> ack_o on the 4th cycle after stb; readback returns 32'hAA22CC44.
3. Incrementing read burst, bte=01, start adr 0x0C, four beats with the last at cti=111 -> four consecutive ack cycles; words returned from 0x0C, 0x00, 0x04, 0x08; ack_o low on the 5th cycle.
4. Linear write burst of 8 beats from 0x200, then a classic read at 0x21C -> last written value returned; beat_cnt_o advances by 9.
5. Classic access to 0xFFFF_0010 -> err_o high for one cycle, ack_o stays 0, err_cnt_o=1. A linear burst starting at 0xFFFE_FFFC -> one ack, then err on the second beat, then IDLE.
6. Reset driven low at beat 2 of a 4-beat write burst -> ack_o, err_o and the counters go to 0 immediately; beats 3 and 4 are never written; earlier memory contents are retained.
